bp_fe_bp_perceptron_train_ctrl: RTL and testbench
=================================================

// Module: bp_fe_bp_perceptron_train_ctrl
//
// PURPOSE
// Training sequencer for the perceptron branch predictor's weight table. It queues resolved-branch
// updates, decides whether each one needs training, and performs a read-modify-write (RMW) of the
// weight row. The weight table is a single-port synchronous RAM, shared with the frontend
// prediction read. Prediction reads normally win the port; a starvation limit bounds how long
// training can be held off.
//
// PARAMETERS
// bht_idx_width_p  6   weight-row index width (rows = 2**bht_idx_width_p)
// bp_n_hist        8   global history length; a row holds bp_n_hist+1 weights (w0 = bias)
// weight_width_p   8   signed weight width, two's complement
// sum_width_p      12  signed perceptron-sum width
// theta_p          29  training threshold, floor(1.93*bp_n_hist+14)
// fifo_els_p       4   update FIFO depth, power of 2
// starve_lim_p     4   consecutive denied cycles before training takes the port
//
// PORTS
// clk_i         in   1      clock, rising edge
// reset_n_i     in   1      asynchronous active-low reset
// upd_v_i       in   1      resolved-branch update valid
// upd_ready_o   out  1      update FIFO not full; transfer = upd_v_i & upd_ready_o
// upd_idx_i     in   bht_idx_width_p          row used for the prediction
// upd_taken_i   in   1      actual outcome (1 = taken)
// upd_sum_i     in   sum_width_p              signed sum computed at predict time
// upd_hist_i    in   bp_n_hist                history at predict time; bit i pairs with w(i+1)
// pred_v_i      in   1      frontend prediction read request
// pred_idx_i    in   bht_idx_width_p          prediction row
// pred_stall_o  out  1      prediction denied this cycle; frontend retries
// wt_v_o        out  1      weight RAM access enable
// wt_w_o        out  1      1 = write, 0 = read
// wt_addr_o     out  bht_idx_width_p          weight RAM row address
// wt_data_o     out  (bp_n_hist+1)*weight_width_p   write row; w0 in LSBs
// wt_data_i     in   (bp_n_hist+1)*weight_width_p   read row, valid 1 cycle after read
// busy_o        out  1      FIFO non-empty or FSM not in IDLE
//
// BEHAVIOUR
// - Reset: FIFO empty, FSM in IDLE, starvation counter 0.
//   Outputs: upd_ready_o=1, pred_stall_o=0, wt_v_o=0, wt_w_o=0, busy_o=0.
// - Port arbitration, evaluated each cycle:
//   - Training wins when the FSM is in RD or WR and either pred_v_i=0 or starve_cnt==starve_lim_p.
//   - If training wins while pred_v_i=1, assert pred_stall_o.
//   - Otherwise pass the prediction through combinationally:
//     wt_v_o=pred_v_i, wt_w_o=0, wt_addr_o=pred_idx_i.
// - starve_cnt:
//   - increments on each cycle the FSM is in RD/WR and is denied;
//   - clears on every training grant.
// - Training test on the FIFO head (h):
//   - pred = (h.sum >= 0);
//   - train = (pred != h.taken) || (|h.sum| <= theta_p);
//   - |sum| is computed at sum_width_p+1 bits so the most negative value does not overflow.
// - FSM states:
//   - IDLE: if FIFO is empty, stay. If train=0, pop the head (1 cycle, no RAM access) and stay.
//     Otherwise go to RD.
//   - RD: on grant, issue a read (wt_v_o=1, wt_w_o=0, wt_addr_o=h.idx) and go to CAP.
//     If not granted, stay.
//   - CAP: register wt_data_i and compute the new row; always go to WR.
//     The port is free to predictions during CAP.
//   - WR: on grant, issue a write (wt_v_o=1, wt_w_o=1, wt_data_o=new row), pop the FIFO head,
//     and go to IDLE. If not granted, stay.
// - Weight update, with t=+1 if taken else -1, saturating to [-2**(W-1), 2**(W-1)-1]:
//   - w0 += t;
//   - w(i+1) += (upd_taken == hist[i]) ? +1 : -1.
// - Minimum cost: 4 cycles per trained update; 1 cycle per untrained update.
// - FIFO:
//   - A push when full is refused; there is no bypass.
//   - upd_ready_o = !full, registered from FIFO state.
//   - Push and pop in the same cycle are both honoured; occupancy is unchanged.
// - Ordering: updates are strictly in order and never overlap, so back-to-back updates to the
//   same row see each other's writes.
// - Read hazard: a prediction read of a row between its RD and WR returns the pre-update weights.
//   This is accepted; no forwarding.
// - Asynchronous reset mid-RMW abandons the update; the RAM row keeps its old contents.
//
// TESTING
// - Reset, then push idx=3, taken=1, sum=-5, hist=8'hFF, row all 0.
//   -> Read row 3; write w0..w8 = +1; busy_o falls 4 cycles after the push.
// - Push sum=+40, taken=1 (correct, |sum| > 29).
//   -> Popped in 1 cycle; wt_v_o never asserted.
// - Row has w0=127 and w1=-128; push taken=1, hist[0]=0, sum=0.
//   -> w0 stays 127 and w1 stays -128 (saturation).
// - Hold pred_v_i=1 while a training update is pending.
//   -> Training denied for 4 cycles; cycle 5: pred_stall_o=1 and the training read issues.
// - Push 5 updates with no pops possible.
//   -> upd_ready_o=0 after the 4th; 5th held until a pop; order preserved.
// - Assert reset_n_i=0 while in CAP.
//   -> Outputs go to reset values immediately; no write issued; FIFO empty.

Source files
------------

// File: rtl/bp_fe_bp_perceptron_train_ctrl.sv
// Perceptron weight-table training sequencer: queues resolved branches, filters the ones
// that need training, and read-modify-writes the weight row over a port shared with predictions.
module bp_fe_bp_perceptron_train_ctrl #(
  parameter int bht_idx_width_p = 6,
  parameter int bp_n_hist       = 8,
  parameter int weight_width_p  = 8,
  parameter int sum_width_p     = 12,
  parameter int theta_p         = 29,
  parameter int fifo_els_p      = 4,
  parameter int starve_lim_p    = 4
) (
  input  logic                                     clk_i,
  input  logic                                     reset_n_i,
  input  logic                                     upd_v_i,
  output logic                                     upd_ready_o,
  input  logic [bht_idx_width_p-1:0]               upd_idx_i,
  input  logic                                     upd_taken_i,
  input  logic [sum_width_p-1:0]                   upd_sum_i,
  input  logic [bp_n_hist-1:0]                     upd_hist_i,
  input  logic                                     pred_v_i,
  input  logic [bht_idx_width_p-1:0]               pred_idx_i,
  output logic                                     pred_stall_o,
  output logic                                     wt_v_o,
  output logic                                     wt_w_o,
  output logic [bht_idx_width_p-1:0]               wt_addr_o,
  output logic [(bp_n_hist+1)*weight_width_p-1:0]  wt_data_o,
  input  logic [(bp_n_hist+1)*weight_width_p-1:0]  wt_data_i,
  output logic                                     busy_o
);

  localparam int row_w_lp    = (bp_n_hist+1)*weight_width_p;
  localparam int ptr_w_lp    = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int cnt_w_lp    = $clog2(fifo_els_p+1);
  localparam int starve_w_lp = $clog2(starve_lim_p+1);

  localparam logic [cnt_w_lp-1:0]       fifo_full_lp  = cnt_w_lp'(fifo_els_p);
  localparam logic [cnt_w_lp-1:0]       cnt_one_lp    = cnt_w_lp'(1);
  localparam logic [ptr_w_lp-1:0]       ptr_one_lp    = ptr_w_lp'(1);
  localparam logic [starve_w_lp-1:0]    starve_max_lp = starve_w_lp'(starve_lim_p);
  localparam logic [starve_w_lp-1:0]    starve_one_lp = starve_w_lp'(1);
  localparam logic [sum_width_p:0]      theta_lp      = (sum_width_p+1)'(theta_p);
  localparam logic [weight_width_p-1:0] w_max_lp      = {1'b0, {(weight_width_p-1){1'b1}}};
  localparam logic [weight_width_p-1:0] w_min_lp      = {1'b1, {(weight_width_p-1){1'b0}}};
  localparam logic [weight_width_p-1:0] w_one_lp      = {{(weight_width_p-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [bht_idx_width_p-1:0] idx;
    logic                       taken;
    logic [sum_width_p-1:0]     sum;
    logic [bp_n_hist-1:0]       hist;
  } upd_entry_t;

  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_CAP, ST_WR} state_e;

  upd_entry_t                 fifo_mem [fifo_els_p];
  logic [ptr_w_lp-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [cnt_w_lp-1:0]        count_reg;
  state_e                     state_reg, state_next;
  logic [starve_w_lp-1:0]     starve_cnt_reg;
  logic [row_w_lp-1:0]        new_row_reg;
  logic [row_w_lp-1:0]        new_row;

  upd_entry_t                 head;
  logic                       fifo_empty, fifo_full;
  logic                       push, pop;
  logic                       train_req, grant, train;
  logic [sum_width_p:0]       sum_ext, sum_abs;

  // Update FIFO: small register file, head read combinationally
  assign fifo_empty  = (count_reg == '0);
  assign fifo_full   = (count_reg == fifo_full_lp);
  assign upd_ready_o = ~fifo_full;
  assign push        = upd_v_i & ~fifo_full;
  assign head        = fifo_mem[rd_ptr_reg];

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= '{idx: upd_idx_i, taken: upd_taken_i, sum: upd_sum_i, hist: upd_hist_i};
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + ptr_one_lp;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + ptr_one_lp;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + cnt_one_lp;
        2'b01:   count_reg <= count_reg - cnt_one_lp;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Sum magnitude is taken one bit wider so the most negative sum stays positive
  assign sum_ext = {head.sum[sum_width_p-1], head.sum};
  assign sum_abs = sum_ext[sum_width_p] ? -sum_ext : sum_ext;
  assign train   = ((~head.sum[sum_width_p-1]) != head.taken) || (sum_abs <= theta_lp);

  // Saturating +/-1 per weight; w0 follows the outcome, w(i+1) follows agreement with hist[i]
  genvar gi;
  generate
    for (gi = 0; gi <= bp_n_hist; gi++) begin : g_weight
      logic [weight_width_p-1:0] w_old;
      logic                      w_inc;
      assign w_old = wt_data_i[gi*weight_width_p +: weight_width_p];
      if (gi == 0) begin : g_bias
        assign w_inc = head.taken;
      end else begin : g_hist
        assign w_inc = (head.taken == head.hist[gi-1]);
      end
      assign new_row[gi*weight_width_p +: weight_width_p] =
        w_inc ? ((w_old == w_max_lp) ? w_old : w_old + w_one_lp)
              : ((w_old == w_min_lp) ? w_old : w_old - w_one_lp);
    end
  endgenerate

  assign train_req = (state_reg == ST_RD) || (state_reg == ST_WR);
  assign grant     = train_req && (!pred_v_i || (starve_cnt_reg == starve_max_lp));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg      <= ST_IDLE;
      starve_cnt_reg <= '0;
      new_row_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (grant) begin
        starve_cnt_reg <= '0;
      end else if (train_req) begin
        starve_cnt_reg <= starve_cnt_reg + starve_one_lp;
      end
      if (state_reg == ST_CAP) new_row_reg <= new_row;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pop          = 1'b0;
    pred_stall_o = grant && pred_v_i;
    wt_v_o       = pred_v_i;
    wt_w_o       = 1'b0;
    wt_addr_o    = pred_idx_i;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (!train) pop = 1'b1;
          else        state_next = ST_RD;
        end
      end
      ST_RD: begin
        if (grant) begin
          wt_v_o     = 1'b1;
          wt_addr_o  = head.idx;
          state_next = ST_CAP;
        end
      end
      ST_CAP: state_next = ST_WR;
      ST_WR: begin
        if (grant) begin
          wt_v_o     = 1'b1;
          wt_w_o     = 1'b1;
          wt_addr_o  = head.idx;
          pop        = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign wt_data_o = new_row_reg;
  assign busy_o    = !fifo_empty || (state_reg != ST_IDLE);

endmodule

// File: tb/tb_bp_fe_bp_perceptron_train_ctrl.sv
// Bench for the perceptron training sequencer: table vectors, corner sequences and
// randomized traffic checked against an integer weight model with a write scoreboard.
module tb_bp_fe_bp_perceptron_train_ctrl;

  logic        clk;
  logic        reset_n;
  logic        upd_v;
  logic        upd_ready;
  logic [5:0]  upd_idx;
  logic        upd_taken;
  logic [11:0] upd_sum;
  logic [7:0]  upd_hist;
  logic        pred_v;
  logic [5:0]  pred_idx;
  logic        pred_stall;
  logic        wt_v;
  logic        wt_w;
  logic [5:0]  wt_addr;
  logic [71:0] wt_data_out;
  logic [71:0] wt_data_in;
  logic        busy;

  bp_fe_bp_perceptron_train_ctrl dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .upd_v_i(upd_v), .upd_ready_o(upd_ready), .upd_idx_i(upd_idx),
    .upd_taken_i(upd_taken), .upd_sum_i(upd_sum), .upd_hist_i(upd_hist),
    .pred_v_i(pred_v), .pred_idx_i(pred_idx), .pred_stall_o(pred_stall),
    .wt_v_o(wt_v), .wt_w_o(wt_w), .wt_addr_o(wt_addr),
    .wt_data_o(wt_data_out), .wt_data_i(wt_data_in), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int wr_seen = 0;

  typedef struct {
    logic [5:0]  idx;
    logic [71:0] row;
  } wr_t;
  wr_t expq[$];
  int  shadow [64][9];

  // Weight RAM environment with a preload port for corner-case rows
  logic [71:0] ram [64];
  logic        pre_v;
  logic [5:0]  pre_idx;
  logic [71:0] pre_row;

  initial begin
    for (int i = 0; i < 64; i++) ram[i] <= '0;
    wt_data_in <= '0;
    forever begin
      @(posedge clk);
      if (pre_v) ram[pre_idx] <= pre_row;
      else if (wt_v) begin
        if (wt_w) ram[wt_addr] <= wt_data_out;
        else      wt_data_in   <= ram[wt_addr];
      end
    end
  end

  task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // Reference: every accepted update is judged in order; trained ones produce one expected write
  function automatic void model_accept(input logic [5:0] idx, input logic taken,
                                       input logic [11:0] sum, input logic [7:0] hist);
    int s, a, w, d;
    bit pred, train;
    wr_t e;
    s     = int'($signed(sum));
    pred  = (s >= 0);
    a     = (s < 0) ? -s : s;
    train = (pred != taken) || (a <= 29);
    if (!train) return;
    e.idx = idx;
    e.row = '0;
    for (int j = 0; j < 9; j++) begin
      if (j == 0) d = taken ? 1 : -1;
      else        d = (taken == hist[j-1]) ? 1 : -1;
      w = shadow[idx][j] + d;
      if (w > 127)  w = 127;
      if (w < -128) w = -128;
      shadow[idx][j] = w;
      e.row[j*8 +: 8] = w[7:0];
    end
    expq.push_back(e);
  endfunction

  // Write scoreboard and prediction pass-through check
  always begin
    @(negedge clk);
    #2;
    if (reset_n) begin
      if (wt_v && wt_w) begin
        wr_t e;
        wr_seen++;
        if (expq.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: addr=%0d data=%0h, required no write", wt_addr, wt_data_out);
        end else begin
          e = expq.pop_front();
          check("write_addr", 72'(wt_addr), 72'(e.idx));
          check("write_row", wt_data_out, e.row);
        end
      end
      if (pred_v && !pred_stall)
        check("pred_pass", 72'({wt_v, wt_w, wt_addr}), 72'({1'b1, 1'b0, pred_idx}));
    end
  end

  logic pred_rand_en = 1'b0;
  always @(negedge clk) begin
    if (pred_rand_en) begin
      pred_v   = ($urandom_range(0, 3) == 0);
      pred_idx = 6'($urandom_range(0, 63));
    end
  end

  task automatic push_upd(input logic [5:0] idx, input logic taken, input logic [11:0] sum,
                          input logic [7:0] hist, output int waited);
    waited    = 0;
    upd_v     = 1'b1;
    upd_idx   = idx;
    upd_taken = taken;
    upd_sum   = sum;
    upd_hist  = hist;
    while (!upd_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (!upd_ready) begin
      n_fail++;
      $display("FAIL push_accept: ready=0 after %0d cycles, required 1", waited);
    end else begin
      model_accept(idx, taken, sum, hist);
      $display("push idx=%0d taken=%0b sum=%0d hist=%02h waited=%0d",
               idx, taken, $signed(sum), hist, waited);
    end
    @(negedge clk);
    upd_v = 1'b0;
  endtask

  task automatic wait_idle(input int lim, input string name);
    int c = 0;
    while ((busy || expq.size() != 0) && c < lim) begin
      @(negedge clk);
      c++;
    end
    #1;
    check({name, "_busy"}, 72'(busy), 72'd0);
    check({name, "_pending"}, 72'(expq.size()), 72'd0);
    @(negedge clk);
  endtask

  typedef struct {
    logic [5:0]  idx;
    logic        taken;
    logic [11:0] sum;
    logic [7:0]  hist;
    logic        exp_train;
  } vec_t;
  vec_t vecs[11];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int waited, busy_n, wtv_n, stall_n, first_k, second_k;
    logic [5:0] rd_addr;
    logic first_w, second_w;
    int wr_before;

    vecs[0]  = '{6'd3, 1'b1, 12'hFFB, 8'hFF, 1'b1};  // -5 mispredicted
    vecs[1]  = '{6'd4, 1'b1, 12'd40,  8'h5A, 1'b0};  // confident, correct
    vecs[2]  = '{6'd5, 1'b1, 12'd29,  8'h33, 1'b1};  // |sum| == theta
    vecs[3]  = '{6'd5, 1'b1, 12'd30,  8'h33, 1'b0};  // |sum| == theta+1
    vecs[4]  = '{6'd6, 1'b0, 12'hFE3, 8'h0F, 1'b1};  // -29
    vecs[5]  = '{6'd6, 1'b0, 12'hFE2, 8'h0F, 1'b0};  // -30
    vecs[6]  = '{6'd7, 1'b0, 12'h800, 8'hC3, 1'b0};  // most negative, correct
    vecs[7]  = '{6'd7, 1'b1, 12'h800, 8'hC3, 1'b1};  // most negative, wrong
    vecs[8]  = '{6'd8, 1'b0, 12'd0,   8'h81, 1'b1};  // sum 0 predicts taken
    vecs[9]  = '{6'd8, 1'b1, 12'h7FF, 8'h81, 1'b0};  // most positive, correct
    vecs[10] = '{6'd9, 1'b0, 12'd100, 8'hAA, 1'b1};  // confident, wrong

    reset_n = 1'b0; upd_v = 1'b0; upd_idx = '0; upd_taken = 1'b0; upd_sum = '0;
    upd_hist = '0; pred_v = 1'b0; pred_idx = '0; pre_v = 1'b0; pre_idx = '0; pre_row = '0;
    for (int i = 0; i < 64; i++) for (int j = 0; j < 9; j++) shadow[i][j] = 0;

    @(negedge clk);
    #1;
    check("reset_outputs", 72'({upd_ready, pred_stall, wt_v, wt_w, busy}), 72'(5'b10000));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Table: cycle cost and RAM access count per update
    for (int i = 0; i < 11; i++) begin
      push_upd(vecs[i].idx, vecs[i].taken, vecs[i].sum, vecs[i].hist, waited);
      busy_n = 0; wtv_n = 0; rd_addr = '1;
      for (int k = 0; k < 20; k++) begin
        #1;
        if (!busy) break;
        busy_n++;
        if (wt_v) wtv_n++;
        if (wt_v && !wt_w) rd_addr = wt_addr;
        @(negedge clk);
      end
      @(negedge clk);
      check($sformatf("vec%0d_busy_cycles", i), 72'(busy_n), vecs[i].exp_train ? 72'd4 : 72'd1);
      check($sformatf("vec%0d_ram_accesses", i), 72'(wtv_n), vecs[i].exp_train ? 72'd2 : 72'd0);
      if (vecs[i].exp_train) check($sformatf("vec%0d_read_addr", i), 72'(rd_addr), 72'(vecs[i].idx));
    end
    check("row3_all_plus1", ram[3], 72'h01_0101_0101_0101_0101);

    // Saturation at both ends
    pre_v = 1'b1; pre_idx = 6'd10; pre_row = {56'h0, 8'h80, 8'h7F};
    shadow[10][0] = 127; shadow[10][1] = -128;
    @(negedge clk);
    pre_v = 1'b0;
    push_upd(6'd10, 1'b1, 12'd0, 8'h00, waited);
    wait_idle(50, "sat");
    check("sat_w0", 72'(ram[10][7:0]), 72'h7F);
    check("sat_w1", 72'(ram[10][15:8]), 72'h80);

    // Starvation: prediction held high the whole time
    pred_v = 1'b1; pred_idx = 6'd7;
    push_upd(6'd12, 1'b1, 12'hFFB, 8'h96, waited);
    stall_n = 0; first_k = 0; second_k = 0; first_w = 1'b0; second_w = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      #1;
      if (pred_stall) begin
        stall_n++;
        if (stall_n == 1) begin first_k = k; first_w = wt_w; end
        if (stall_n == 2) begin second_k = k; second_w = wt_w; end
        check($sformatf("starve_addr_k%0d", k), 72'(wt_addr), 72'd12);
      end
      @(negedge clk);
    end
    check("starve_stall_count", 72'(stall_n), 72'd2);
    check("starve_read_cycle", 72'(first_k), 72'd6);
    check("starve_read_kind", 72'(first_w), 72'd0);
    check("starve_write_cycle", 72'(second_k), 72'd12);
    check("starve_write_kind", 72'(second_w), 72'd1);
    wait_idle(50, "starve");

    // FIFO full: training held off so nothing pops for a while
    for (int i = 0; i < 4; i++) push_upd(6'(20 + i), 1'b1, 12'hFFB, 8'($urandom_range(0, 255)), waited);
    #1;
    check("fifo_full_ready", 72'(upd_ready), 72'd0);
    @(negedge clk);
    push_upd(6'd24, 1'b1, 12'hFFB, 8'h3C, waited);
    check("fifo_fifth_held", 72'(waited > 0), 72'd1);
    wait_idle(300, "fifo");
    pred_v = 1'b0;

    // Asynchronous reset in CAP abandons the update
    wr_before = wr_seen;
    upd_v = 1'b1; upd_idx = 6'd30; upd_taken = 1'b1; upd_sum = 12'hFFB; upd_hist = 8'h00;
    $display("push idx=30 taken=1 sum=-5 hist=00 (to be abandoned)");
    @(negedge clk); upd_v = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_cap_outputs", 72'({upd_ready, pred_stall, wt_v, wt_w, busy}), 72'(5'b10000));
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    check("rst_no_write", 72'(wr_seen - wr_before), 72'd0);
    check("rst_fifo_empty", 72'({busy, upd_ready}), 72'(2'b01));
    check("rst_row_kept", ram[30], 72'd0);
    @(negedge clk);

    // Randomized traffic on a few rows, with random prediction contention
    pred_rand_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      int s;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      s = int'($urandom_range(0, 120)) - 60;
      push_upd(6'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 12'(s),
               8'($urandom_range(0, 255)), waited);
    end
    wait_idle(3000, "random");
    pred_rand_en = 1'b0;
    @(negedge clk);
    pred_v = 1'b0;
    for (int r = 0; r < 4; r++) begin
      logic [71:0] exp_row;
      for (int j = 0; j < 9; j++) exp_row[j*8 +: 8] = 8'(shadow[r][j]);
      check($sformatf("random_row%0d", r), ram[r], exp_row);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
